freq_meter: RTL and testbench

Measures frequency and period of a slow, clock-unrelated digital signal (typically one of the divided outputs of the prescaler bank) against `clk_in`. Counts rising edges of `sig_in` over a fixed gate window of 2^GATE_N clock cycles, and independently measures the clock-cycle distance between consecutive rising edges. Used as the on-chip checker and readout for the prescaler outputs.

---
 rtl/freq_meter_if.sv | 37 +++
 rtl/freq_meter.sv | 119 +++++++++++
 tb/tb_freq_meter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/freq_meter_if.sv
// Signal bundle between a frequency-meter client and the meter: stimulus/enable in,
// windowed edge count and edge-to-edge period out.
interface freq_meter_if #(
  parameter int unsigned CW = 16,
  parameter int unsigned PW = 24
);
  logic          sig_in;
  logic          enable;
  logic [CW-1:0] count;
  logic          count_ovf;
  logic          count_valid;
  logic [PW-1:0] period;
  logic          period_ovf;
  logic          period_valid;

  modport master (
    output sig_in,
    output enable,
    input  count,
    input  count_ovf,
    input  count_valid,
    input  period,
    input  period_ovf,
    input  period_valid
  );

  modport slave (
    input  sig_in,
    input  enable,
    output count,
    output count_ovf,
    output count_valid,
    output period,
    output period_ovf,
    output period_valid
  );
endinterface

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous signal over 2^GATE_N-cycle gate windows and
// measures the clock-cycle distance between consecutive rising edges.
module freq_meter #(
  parameter int unsigned GATE_N = 20,
  parameter int unsigned CW     = 16,
  parameter int unsigned PW     = 24
) (
  input  logic          clk_in,
  input  logic          rstn,
  freq_meter_if.slave   bus
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e              state;
  logic                s1, s2, s3;
  logic [GATE_N-1:0]   wcnt;
  logic [CW-1:0]       ecnt;
  logic [PW-1:0]       pcnt;
  logic                armed;

  logic [CW-1:0]       count_q;
  logic                count_ovf_q;
  logic                count_valid_q;
  logic [PW-1:0]       period_q;
  logic                period_ovf_q;
  logic                period_valid_q;

  logic                sig_edge;
  logic                win_end;
  logic [CW-1:0]       ecnt_next;

  assign sig_edge = s2 & ~s3;
  assign win_end  = (wcnt == '1);

  // Edge count including the current-cycle edge, held at the ceiling.
  always_comb begin
    ecnt_next = ecnt;
    if (sig_edge && (ecnt != '1)) begin
      ecnt_next = ecnt + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state          <= StIdle;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      wcnt           <= '0;
      ecnt           <= '0;
      pcnt           <= '0;
      armed          <= 1'b0;
      count_q        <= '0;
      count_ovf_q    <= 1'b0;
      count_valid_q  <= 1'b0;
      period_q       <= '0;
      period_ovf_q   <= 1'b0;
      period_valid_q <= 1'b0;
    end else begin
      s1             <= bus.sig_in;
      s2             <= s1;
      s3             <= s2;
      count_valid_q  <= 1'b0;
      period_valid_q <= 1'b0;
      case (state)
        StIdle: begin
          wcnt  <= '0;
          ecnt  <= '0;
          pcnt  <= '0;
          armed <= 1'b0;
          if (bus.enable) begin
            state <= StRun;
          end
        end
        StRun: begin
          if (!bus.enable) begin
            // Abort: partial window and half-measured period are discarded.
            state <= StIdle;
            wcnt  <= '0;
            ecnt  <= '0;
            pcnt  <= '0;
            armed <= 1'b0;
          end else begin
            wcnt <= wcnt + GATE_N'(1);
            if (win_end) begin
              count_q       <= ecnt_next;
              count_ovf_q   <= (ecnt_next == '1);
              count_valid_q <= 1'b1;
              ecnt          <= '0;
            end else begin
              ecnt <= ecnt_next;
            end
            if (sig_edge) begin
              if (armed) begin
                period_q       <= pcnt;
                period_ovf_q   <= (pcnt == '1);
                period_valid_q <= 1'b1;
              end
              armed <= 1'b1;
              pcnt  <= PW'(1);
            end else if (armed && (pcnt != '1)) begin
              pcnt <= pcnt + PW'(1);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.count        = count_q;
  assign bus.count_ovf    = count_ovf_q;
  assign bus.count_valid  = count_valid_q;
  assign bus.period       = period_q;
  assign bus.period_ovf   = period_ovf_q;
  assign bus.period_valid = period_valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Two meters (wide and narrow counters, 16-cycle gate) share one stimulus and are compared
// every cycle against a window/edge-timestamp reference model.
module tb_freq_meter;

  localparam int unsigned GateN = 4;
  localparam int          Win   = 16;

  logic clk;
  logic rstn;
  logic sig;
  logic en;

  freq_meter_if #(.CW(16), .PW(24)) bus_a ();
  freq_meter_if #(.CW(2),  .PW(4))  bus_b ();

  assign bus_a.sig_in = sig;
  assign bus_a.enable = en;
  assign bus_b.sig_in = sig;
  assign bus_b.enable = en;

  freq_meter #(.GATE_N(GateN), .CW(16), .PW(24)) dut_a (
    .clk_in (clk),
    .rstn   (rstn),
    .bus    (bus_a)
  );

  freq_meter #(.GATE_N(GateN), .CW(2), .PW(4)) dut_b (
    .clk_in (clk),
    .rstn   (rstn),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: edges as timestamps, windows as multiples of Win after run start.
  longint cmax [2] = '{65535, 3};
  longint pmax [2] = '{16777215, 15};
  bit     h0, h1, h2, h3;
  bit     running;
  int     cur_n = 0;
  int     run_start;
  int     last_e;
  int     win_edges;
  longint exp_count [2];
  bit     exp_covf  [2];
  bit     exp_cv    [2];
  longint exp_period[2];
  bit     exp_povf  [2];
  bit     exp_pv    [2];

  task automatic model_clear();
    h0 = 0; h1 = 0; h2 = 0; h3 = 0;
    running = 0;
    last_e  = -1;
    win_edges = 0;
    for (int i = 0; i < 2; i++) begin
      exp_count[i] = 0; exp_covf[i] = 0; exp_cv[i] = 0;
      exp_period[i] = 0; exp_povf[i] = 0; exp_pv[i] = 0;
    end
  endtask

  task automatic model_step();
    bit edge_now;
    longint gap;
    h3 = h2; h2 = h1; h1 = h0; h0 = sig;
    edge_now = h2 && !h3;
    for (int i = 0; i < 2; i++) begin
      exp_cv[i] = 0;
      exp_pv[i] = 0;
    end
    if (!running) begin
      if (en) begin
        running   = 1;
        run_start = cur_n;
        win_edges = 0;
        last_e    = -1;
      end
    end else if (!en) begin
      running = 0;
      last_e  = -1;
    end else begin
      if (edge_now) begin
        win_edges++;
        if (last_e >= 0) begin
          gap = cur_n - last_e;
          for (int i = 0; i < 2; i++) begin
            exp_period[i] = (gap >= pmax[i]) ? pmax[i] : gap;
            exp_povf[i]   = (gap >= pmax[i]);
            exp_pv[i]     = 1;
          end
        end
        last_e = cur_n;
      end
      if ((cur_n - run_start) % Win == 0) begin
        for (int i = 0; i < 2; i++) begin
          exp_count[i] = (win_edges >= cmax[i]) ? cmax[i] : win_edges;
          exp_covf[i]  = (win_edges >= cmax[i]);
          exp_cv[i]    = 1;
        end
        win_edges = 0;
      end
    end
  endtask

  task automatic check_all();
    check_eq("a.count",        bus_a.count,        exp_count[0]);
    check_eq("a.count_ovf",    bus_a.count_ovf,    exp_covf[0]);
    check_eq("a.count_valid",  bus_a.count_valid,  exp_cv[0]);
    check_eq("a.period",       bus_a.period,       exp_period[0]);
    check_eq("a.period_ovf",   bus_a.period_ovf,   exp_povf[0]);
    check_eq("a.period_valid", bus_a.period_valid, exp_pv[0]);
    check_eq("b.count",        bus_b.count,        exp_count[1]);
    check_eq("b.count_ovf",    bus_b.count_ovf,    exp_covf[1]);
    check_eq("b.count_valid",  bus_b.count_valid,  exp_cv[1]);
    check_eq("b.period",       bus_b.period,       exp_period[1]);
    check_eq("b.period_ovf",   bus_b.period_ovf,   exp_povf[1]);
    check_eq("b.period_valid", bus_b.period_valid, exp_pv[1]);
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      #1;
      cur_n++;
      if (!rstn) model_clear();
      else       model_step();
      check_all();
    end
  end

  // Inputs change only on the falling edge.
  task automatic sq(input int hi, input int lo, input int reps);
    for (int k = 0; k < reps; k++) begin
      sig = 1'b1;
      repeat (hi) @(negedge clk);
      sig = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rstn = 1'b0;
    model_clear();
    #1;
    check_all();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    sig  = 1'b0;
    en   = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Period 4, then period 8 at every phase offset.
    en = 1'b1;
    sq(2, 2, 24);
    for (int sh = 0; sh < 8; sh++) begin
      sig = 1'b0;
      repeat (sh) @(negedge clk);
      sq(4, 4, 6);
    end

    // Period 2 saturates the narrow counter; then back to period 8.
    sq(1, 1, 40);
    sq(4, 4, 8);

    // Long gap saturates the narrow period counter, then a 5-cycle period.
    sq(1, 30, 1);
    sq(1, 4, 4);

    // Abort at wcnt 9, keep toggling while idle, then re-enable.
    sq(2, 2, 6);
    for (int k = 0; k < 40; k++) begin
      if (running && ((cur_n - run_start) % Win == 9)) break;
      @(negedge clk);
    end
    en = 1'b0;
    sq(2, 2, 3);
    en = 1'b1;
    sq(3, 3, 12);

    // Random widths with occasional enable drops.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) en = 1'b0;
      else if ($urandom_range(0, 3) == 0) en = 1'b1;
      sq($urandom_range(1, 10), $urandom_range(1, 10), 1);
    end

    // Asynchronous reset mid-window with live outputs, then period 4 from scratch.
    en = 1'b1;
    sq(2, 2, 10);
    async_reset();
    sq(2, 2, 20);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
